// File: rtl/mmio_uart_tx_if.sv
// ============================================================================
// mmio_uart_tx_if : processor load/store bus into the UART transmitter window
// Rev 1.0
// ============================================================================
`default_nettype none

interface mmio_uart_tx_if;
  logic        MemWrite;
  logic [31:0] DataAdr;
  logic [31:0] WriteData;
  logic [31:0] ReadData;

  modport master (
    output MemWrite,
    output DataAdr,
    output WriteData,
    input  ReadData
  );

  modport slave (
    input  MemWrite,
    input  DataAdr,
    input  WriteData,
    output ReadData
  );
endinterface

`default_nettype wire

// File: rtl/mmio_uart_tx.sv
// ============================================================================
// mmio_uart_tx : memory-mapped 8N1 UART transmitter with a byte FIFO
// Rev 1.0
// ============================================================================
`default_nettype none

module mmio_uart_tx #(
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0F00,
  parameter int          CLKS_PER_BIT = 16,
  parameter int          FIFO_DEPTH   = 8
) (
  input  wire logic     clk,
  input  wire logic     reset,
  mmio_uart_tx_if.slave bus,
  output logic          tx,
  output logic          busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;
  logic [7:0]    mem_q [FIFO_DEPTH];

  logic        hit;
  logic [1:0]  offset;
  logic        wr_data, wr_ctrl, flush, clr_ovf;
  logic        full, empty, push_ok, pop_req, do_pop, bit_end;
  logic [7:0]  head;
  logic [31:0] count_ext;
  logic [3:0]  count_sat;
  logic [31:0] status;
  logic        unused_bits;

  assign hit     = (bus.DataAdr[31:4] == BASE_ADDR[31:4]);
  assign offset  = bus.DataAdr[3:2];
  assign wr_data = bus.MemWrite && hit && (offset == 2'd0);
  assign wr_ctrl = bus.MemWrite && hit && (offset == 2'd2);
  assign flush   = wr_ctrl && bus.WriteData[0];
  assign clr_ovf = wr_ctrl && bus.WriteData[1];

  assign full    = (count_q == CW'(FIFO_DEPTH));
  assign empty   = (count_q == '0);
  assign push_ok = wr_data && !full;
  assign head    = mem_q[rd_ptr_q];
  assign bit_end = (baud_q == BW'(CLKS_PER_BIT - 1));

  // The FIFO is drained either from idle or at the last stop-bit cycle, so
  // back-to-back frames have no idle gap; a flush vetoes the pop.
  assign pop_req = !empty && ((state_q == S_IDLE) || ((state_q == S_STOP) && bit_end));
  assign do_pop  = pop_req && !flush;

  assign count_ext = 32'(count_q);
  assign count_sat = (count_ext > 32'd15) ? 4'hF : count_ext[3:0];
  assign status    = {24'd0, count_sat, ovf_q, (state_q != S_IDLE), empty, full};

  assign bus.ReadData = (hit && (offset == 2'd1)) ? status : 32'd0;
  assign tx           = tx_q;
  assign busy         = (state_q != S_IDLE) || !empty;
  assign unused_bits  = ^{bus.WriteData[31:8], bus.DataAdr[1:0]};

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (flush) begin
      rd_ptr_d = wr_ptr_q;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push_ok, do_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
    if (wr_data && full) ovf_d = 1'b1;
    else if (clr_ovf)    ovf_d = 1'b0;
  end

  always_comb begin
    state_d   = state_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    tx_d      = tx_q;
    baud_d    = ((state_q == S_IDLE) || bit_end) ? '0 : baud_q + 1'b1;
    case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        if (do_pop) begin
          state_d = S_START;
          shift_d = head;
          tx_d    = 1'b0;
        end
      end
      S_START: begin
        if (bit_end) begin
          state_d   = S_DATA;
          bit_idx_d = 3'd0;
          tx_d      = shift_q[0];
        end
      end
      S_DATA: begin
        if (bit_end) begin
          if (bit_idx_q == 3'd7) begin
            state_d = S_STOP;
            tx_d    = 1'b1;
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
            shift_d   = {1'b0, shift_q[7:1]};
            tx_d      = shift_q[1];
          end
        end
      end
      S_STOP: begin
        if (bit_end) begin
          if (do_pop) begin
            state_d = S_START;
            shift_d = head;
            tx_d    = 1'b0;
          end else begin
            state_d = S_IDLE;
            tx_d    = 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      baud_q    <= '0;
      bit_idx_q <= 3'd0;
      shift_q   <= 8'd0;
      tx_q      <= 1'b1;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
    end
  end

  // Storage needs no reset: pointers and count define which entries are valid.
  always_ff @(posedge clk) begin
    if (push_ok && !flush) mem_q[wr_ptr_q] <= bus.WriteData[7:0];
  end

endmodule

`default_nettype wire
